// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative multiply / multiply-accumulate unit with HI/LO.
// Multiplies retire STEP_BITS multiplier bits per CALC cycle. The final
// result is held for one commit cycle after FINISH. HI/LO or the MUL
// result register are written on that commit edge, together with Done.
// Optional build macro: MULT_ZERO_SKIP_EN (a zero operand bypasses CALC).
module hilo_mult_unit #(
    parameter int STEP_BITS = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [5:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        Stall,
    output logic [31:0] Result,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int N = 32 / STEP_BITS;
    localparam logic [5:0] LAST_CNT = 6'(N - 1);

    localparam logic [5:0] OP_MULT  = 6'b100100;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b100011;
    localparam logic [5:0] OP_MADD  = 6'b000101;
    localparam logic [5:0] OP_MSUB  = 6'b100101;
    localparam logic [5:0] OP_MTHI  = 6'b001101;
    localparam logic [5:0] OP_MTLO  = 6'b101101;
    localparam logic [5:0] OP_MFHI  = 6'b001110;
    localparam logic [5:0] OP_MFLO  = 6'b101110;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplr_q, mplr_d;
    logic [63:0] prod_q, prod_d;
    logic        neg_q, neg_d;
    logic        commit_q, commit_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_q, mul_d;

    logic        is_mul_op, is_signed_op, is_hilo_op;
    logic [31:0] mag_a, mag_b;
    logic [63:0] partial, acc_sum, acc_diff;
    logic        busy;

    // Operation decode and operand magnitudes for the signed forms.
    always_comb begin
        is_mul_op    = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU) ||
                       (ALUControl == OP_MUL)  || (ALUControl == OP_MADD)  ||
                       (ALUControl == OP_MSUB);
        is_signed_op = is_mul_op && (ALUControl != OP_MULTU);
        is_hilo_op   = is_mul_op || (ALUControl == OP_MTHI) || (ALUControl == OP_MTLO) ||
                       (ALUControl == OP_MFHI) || (ALUControl == OP_MFLO);
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        mag_a = (is_signed_op && A[31]) ? (~A + 32'd1) : A;
        mag_b = (is_signed_op && B[31]) ? (~B + 32'd1) : B;
    end

    // Shift-add partial sum for the multiplier bits retired this cycle.
    always_comb begin
        partial = 64'd0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (mplr_q[j]) partial = partial + (mcand_q << j);
        end
        acc_sum  = {hi_q, lo_q} + prod_q;
        acc_diff = {hi_q, lo_q} - prod_q;
    end

    assign busy = (state_q != S_IDLE) || commit_q;

    // Next-state logic: FSM sequencing, operand capture, HI/LO commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        commit_d = 1'b0;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_d    = mul_q;
        case (state_q)
            S_IDLE: begin
                if (commit_q) begin
                    // Signed product is final; apply it to the architectural state.
                    done_d = 1'b1;
                    case (op_q)
                        OP_MADD: {hi_d, lo_d} = acc_sum;
                        OP_MSUB: {hi_d, lo_d} = acc_diff;
                        OP_MUL:  mul_d = prod_q[31:0];
                        default: {hi_d, lo_d} = prod_q;
                    endcase
                end else if (Start) begin
                    if (is_mul_op) begin
                        op_d    = ALUControl;
                        mcand_d = {32'd0, mag_a};
                        mplr_d  = mag_b;
                        prod_d  = 64'd0;
                        neg_d   = is_signed_op && (A[31] ^ B[31]);
                        cnt_d   = 6'd0;
`ifdef MULT_ZERO_SKIP_EN
                        state_d = ((A == 32'd0) || (B == 32'd0)) ? S_FINISH : S_CALC;
`else
                        state_d = S_CALC;
`endif
                    end else if (ALUControl == OP_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (ALUControl == OP_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                prod_d  = prod_q + partial;
                mcand_d = mcand_q << STEP_BITS;
                mplr_d  = mplr_q >> STEP_BITS;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = S_FINISH;
            end
            S_FINISH: begin
                prod_d   = neg_q ? (~prod_q + 64'd1) : prod_q;
                commit_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight multiply without a write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 6'd0;
            mcand_q  <= 64'd0;
            mplr_q   <= 32'd0;
            prod_q   <= 64'd0;
            neg_q    <= 1'b0;
            commit_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mul_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            commit_q <= commit_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mul_q    <= mul_d;
        end
    end

    assign Busy   = busy;
    assign Done   = done_q;
    assign Stall  = busy && is_hilo_op;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign Result = (ALUControl == OP_MFHI) ? hi_q :
                    (ALUControl == OP_MFLO) ? lo_q : mul_q;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Bench for hilo_mult_unit: directed scenarios, then randomized operations
// compared against an arithmetic reference model of HI/LO/MUL state.
module tb_hilo_mult_unit;
    localparam logic [5:0] OP_MULT  = 6'b100100;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b100011;
    localparam logic [5:0] OP_MADD  = 6'b000101;
    localparam logic [5:0] OP_MSUB  = 6'b100101;
    localparam logic [5:0] OP_MTHI  = 6'b001101;
    localparam logic [5:0] OP_MTLO  = 6'b101101;
    localparam logic [5:0] OP_MFHI  = 6'b001110;
    localparam logic [5:0] OP_MFLO  = 6'b101110;

    logic        Clk = 1'b0;
    logic        Rst, Start;
    logic [5:0]  ALUControl;
    logic [31:0] A, B;
    logic        Busy, Done, Stall;
    logic [31:0] Result, HI, LO;

    int checks = 0;
    int errors = 0;

    // Reference architectural state.
    logic [31:0] m_hi, m_lo, m_mul;

    hilo_mult_unit dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Stall(Stall),
        .Result(Result), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mul(input logic [5:0] c);
        return (c == OP_MULT) || (c == OP_MULTU) || (c == OP_MUL) ||
               (c == OP_MADD) || (c == OP_MSUB);
    endfunction

    // Edges after the Start edge at which Done is seen.
    function automatic int exp_lat(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        if (!is_mul(c)) return 0;
`ifdef MULT_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    task automatic model_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        acc = {m_hi, m_lo};
        if (c == OP_MULTU) p = {32'd0, a} * {32'd0, b};
        else               p = sa * sb;
        case (c)
            OP_MULT, OP_MULTU: {m_hi, m_lo} = p;
            OP_MADD:           {m_hi, m_lo} = acc + p;
            OP_MSUB:           {m_hi, m_lo} = acc - p;
            OP_MUL:            m_mul = p[31:0];
            OP_MTHI:           m_hi = a;
            OP_MTLO:           m_lo = a;
            default: ;
        endcase
    endtask

    // mode 0: plain op; mode 1: inject MTLO Start then hold MFLO while busy.
    task automatic run_op(input string tag, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        int lat, exp;
        bit busy_ok, stall_ok;
        exp = exp_lat(c, a, b);
        ALUControl = c; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = -1; busy_ok = 1'b1; stall_ok = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin @(posedge Clk); #1; end
            if (Done === 1'b1) begin lat = k; break; end
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (mode == 1) begin
                if (k >= 6 && Stall !== 1'b1) stall_ok = 1'b0;
                if (k == 5) begin Start = 1'b1; ALUControl = OP_MTLO; A = 32'h1234; end
                else if (k == 6) begin Start = 1'b0; ALUControl = OP_MFLO; end
            end
        end
        model_op(c, a, b);
        chk({tag, " latency"}, 64'(lat), 64'(exp));
        chk({tag, " busy during op"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, " busy at done"}, {63'd0, Busy}, 64'd0);
        chk({tag, " HI"}, {32'd0, HI}, {32'd0, m_hi});
        chk({tag, " LO"}, {32'd0, LO}, {32'd0, m_lo});
        if (mode == 1) begin
            chk({tag, " stall while busy"}, {63'd0, stall_ok}, 64'd1);
            chk({tag, " stall at done"}, {63'd0, Stall}, 64'd0);
            chk({tag, " MFLO result"}, {32'd0, Result}, {32'd0, m_lo});
        end else if (c == OP_MUL) begin
            chk({tag, " MUL result"}, {32'd0, Result}, {32'd0, m_mul});
        end
    endtask

    initial begin
        logic [5:0]  codes [7];
        logic [5:0]  c;
        logic [31:0] ra, rb;
        codes = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO};

        Rst = 1'b1; Start = 1'b0; ALUControl = 6'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_mul = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset Busy", {63'd0, Busy}, 64'd0);
        chk("reset Done", {63'd0, Done}, 64'd0);
        chk("reset HI", {32'd0, HI}, 64'd0);
        chk("reset LO", {32'd0, LO}, 64'd0);
        chk("reset Result", {32'd0, Result}, 64'd0);
        Rst = 1'b0;

        // Signed multiply with mixed signs.
        run_op("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 0);
        chk("MULT -3*7 HI const", {32'd0, HI}, 64'hFFFFFFFF);
        chk("MULT -3*7 LO const", {32'd0, LO}, 64'hFFFFFFEB);

        run_op("MULTU max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("MULTU HI const", {32'd0, HI}, 64'hFFFFFFFE);
        run_op("MUL", OP_MUL, 32'h00010000, 32'h00010001, 0);
        chk("MUL result const", {32'd0, Result}, 64'h00010000);

        // Accumulate sequence.
        run_op("MTHI", OP_MTHI, 32'd0, 32'd0, 0);
        run_op("MTLO", OP_MTLO, 32'hFFFFFFFF, 32'd0, 0);
        run_op("MADD 1*1", OP_MADD, 32'd1, 32'd1, 0);
        chk("MADD HI const", {32'd0, HI}, 64'h1);
        run_op("MSUB 2*3", OP_MSUB, 32'd2, 32'd3, 0);
        chk("MSUB LO const", {32'd0, LO}, 64'hFFFFFFFA);

        // Ignored Start and MFLO interlock while a multiply is in flight.
        run_op("MULT inflight", OP_MULT, 32'h80000000, 32'h80000000, 1);
        chk("inflight MTLO ignored", {32'd0, LO}, 64'h0);

        // Reset in the middle of a multiply.
        ALUControl = OP_MULT; A = 32'd9; B = 32'd9; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) begin @(posedge Clk); #1; end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0; m_mul = 32'd0;
        chk("abort Busy", {63'd0, Busy}, 64'd0);
        chk("abort Done", {63'd0, Done}, 64'd0);
        chk("abort HI", {32'd0, HI}, 64'd0);
        chk("abort LO", {32'd0, LO}, 64'd0);
        begin
            bit seen;
            seen = 1'b0;
            repeat (40) begin @(posedge Clk); #1; if (Done === 1'b1) seen = 1'b1; end
            chk("abort no Done", {63'd0, seen}, 64'd0);
        end
        run_op("MULT 5*6", OP_MULT, 32'd5, 32'd6, 0);
        chk("MULT 5*6 LO const", {32'd0, LO}, 64'd30);

        // Zero operand (latency depends on the build option).
        run_op("MULT zero", OP_MULT, 32'd0, 32'h55, 0);

        // Unrelated code with Start: no Done, no state change.
        ALUControl = 6'b111111; A = 32'hDEADBEEF; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("bad code Done", {63'd0, Done}, 64'd0);
        chk("bad code Busy", {63'd0, Busy}, 64'd0);
        chk("bad code HI", {32'd0, HI}, {32'd0, m_hi});

        // Randomized ops with occasional zero / most-negative operands.
        for (int i = 0; i < 24; i++) begin
            c  = codes[$urandom_range(0, 6)];
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: rb = 32'h80000000;
                2: ra = 32'h80000000;
                default: ;
            endcase
            run_op($sformatf("rand%0d op%b", i, c), c, ra, rb, 0);
        end

        // Combinational HI/LO reads without Start.
        ALUControl = OP_MFHI; #1;
        chk("MFHI read", {32'd0, Result}, {32'd0, m_hi});
        ALUControl = OP_MFLO; #1;
        chk("MFLO read", {32'd0, Result}, {32'd0, m_lo});
        chk("idle Stall", {63'd0, Stall}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
